// File: rtl/r_type_fetch_decode_pkg.sv
// r_type_pkg: shared types and constants for the R-type fetch/decode stage.
//   state_t       FSM state encoding
//   OP_RTYPE      opcode value of an R-type instruction
//   HALT_WORD     sentinel instruction that stops the stage
//   *_LSB/*_W     bit positions and widths of the MIPS instruction fields
package r_type_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    localparam logic [5:0]  OP_RTYPE  = 6'd0;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_W   = 6;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int REG_W      = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int FUNCT_W    = 6;

endpackage

// File: rtl/r_type_fetch_decode_if.sv
// r_type_fetch_decode_if: decoded-instruction handshake bus.
//   out_valid/out_ready  valid/ready handshake
//   r1, r2, r3, funct    decoded register selects and function code
//   pc                   byte address of the presented instruction
//   illegal              pulse per skipped non-R-type word
//   halted               stage is in HALT
// master = decode stage, slave = downstream datapath.
interface r_type_fetch_decode_if;

    logic        out_valid;
    logic        out_ready;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  r3;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic        illegal;
    logic        halted;

    modport master (
        output out_valid, r1, r2, r3, funct, pc, illegal, halted,
        input  out_ready
    );

    modport slave (
        input  out_valid, r1, r2, r3, funct, pc, illegal, halted,
        output out_ready
    );

endinterface

// File: rtl/r_type_fetch_decode_instr_mem.sv
// instr_mem: DEPTH x 32 instruction memory.
//   clk, rst_n         clock, async active-low reset (read register only)
//   we, waddr, wdata   synchronous write port
//   re, raddr, rdata   synchronous read port; rdata is the registered word
// The array itself is not reset; the read register is, so that a freshly
// reset stage presents all-zero fields.
module instr_mem #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/r_type_fetch_decode.sv
// r_type_fetch_decode: instruction fetch/decode stage for the R-type datapath.
//   clk, rst_n                    clock, async active-low reset
//   start                         begin fetching at RESET_PC (from IDLE/HALT)
//   load_en, load_addr, load_data imem write port (honoured in IDLE/HALT)
//   dec                           decoded-instruction handshake bus (master)
//
// state  | meaning
// IDLE   | after reset; accepts imem loads, waits for start
// FETCH  | synchronous imem read of word pc into ir
// DECODE | classify ir: present R-type, skip nop/illegal, or halt
// HALT   | stopped; accepts imem loads, start restarts at RESET_PC
module r_type_fetch_decode
    import r_type_pkg::*;
#(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int          AW         = $clog2(IMEM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   load_en,
    input  logic [AW-1:0]          load_addr,
    input  logic [31:0]            load_data,
    r_type_fetch_decode_if.master  dec
);

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] ir;
    logic        mem_we, mem_re;
    logic        valid_c, illegal_c, advance;
    logic        last_word;

    // ir is the memory's read register: it only changes in FETCH, so the
    // fields below are stable for the whole DECODE cycle and any stall.
    instr_mem #(.DEPTH(IMEM_DEPTH), .AW(AW)) u_imem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (mem_re),
        .raddr (pc[AW+1:2]),
        .rdata (ir)
    );

    assign last_word = (pc[AW+1:2] == AW'(IMEM_DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        valid_c   = 1'b0;
        illegal_c = 1'b0;
        advance   = 1'b0;
        case (state)
            ST_IDLE, ST_HALT: begin
                // A load in the same cycle as start wins; start is dropped.
                if (load_en) begin
                    mem_we = 1'b1;
                end else if (start) begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = RESET_PC;
                end
            end
            ST_FETCH: begin
                mem_re    = 1'b1;
                state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                // HALT_WORD has a non-zero opcode, so it must be tested first.
                if (ir == HALT_WORD) begin
                    state_nxt = ST_HALT;
                end else if (ir == 32'd0) begin
                    advance = 1'b1;
                end else if (ir[OPCODE_LSB +: OPCODE_W] != OP_RTYPE) begin
                    illegal_c = 1'b1;
                    advance   = 1'b1;
                end else begin
                    valid_c = 1'b1;
                    advance = dec.out_ready;
                end
                if (advance) begin
                    pc_nxt    = pc + 32'd4;
                    state_nxt = last_word ? ST_HALT : ST_FETCH;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign dec.out_valid = valid_c;
    assign dec.illegal   = illegal_c;
    assign dec.halted    = (state == ST_HALT);
    assign dec.pc        = pc;
    assign dec.r1        = ir[RS_LSB +: REG_W];
    assign dec.r2        = ir[RT_LSB +: REG_W];
    assign dec.r3        = ir[RD_LSB +: REG_W];
    assign dec.funct     = ir[FUNCT_LSB +: FUNCT_W];

endmodule

// File: tb/tb_r_type_fetch_decode.sv
module tb_r_type_fetch_decode;

    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    typedef struct {
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  r3;
        logic [5:0]  funct;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;

    r_type_fetch_decode_if dec ();

    r_type_fetch_decode #(.IMEM_DEPTH(64), .RESET_PC(32'd0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .dec       (dec)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        e.r1    = instr[25:21];
        e.r2    = instr[20:16];
        e.r3    = instr[15:11];
        e.funct = instr[5:0];
        e.pc    = pc;
        sb.push_back(e);
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_r1"}, 64'(dec.r1), 64'(e.r1));
            chk({tag, "_r2"}, 64'(dec.r2), 64'(e.r2));
            chk({tag, "_r3"}, 64'(dec.r3), 64'(e.r3));
            chk({tag, "_funct"}, 64'(dec.funct), 64'(e.funct));
            chk({tag, "_pc"}, 64'(dec.pc), 64'(e.pc));
        end
    endtask

    // Called just after a negedge.
    task automatic load(input int addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = 6'(addr);
        load_data = data;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_until_halt(input string tag, input int budget,
                                  output int n_valid, output int n_illegal,
                                  output logic [31:0] ill_pc, output logic [31:0] last_pc,
                                  output int cycles);
        n_valid = 0; n_illegal = 0; ill_pc = '1; last_pc = '1; cycles = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            cycles = c + 1;
            if (dec.illegal) begin
                n_illegal++;
                ill_pc = dec.pc;
            end
            if (dec.out_valid && dec.out_ready) begin
                n_valid++;
                last_pc = dec.pc;
                check_pop(tag);
            end
            if (dec.halted) break;
        end
        chk({tag, "_halt_reached"}, 64'(dec.halted), 64'd1);
        chk({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
    endtask

    int          nv, ni, cyc;
    logic [31:0] ipc, lpc;
    logic [31:0] w;

    initial begin
        rst_n = 1'b0; start = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        dec.out_ready = 1'b0;
        #1;
        chk("rst_valid", 64'(dec.out_valid), 64'd0);
        chk("rst_r1", 64'(dec.r1), 64'd0);
        chk("rst_r2", 64'(dec.r2), 64'd0);
        chk("rst_r3", 64'(dec.r3), 64'd0);
        chk("rst_funct", 64'(dec.funct), 64'd0);
        chk("rst_pc", 64'(dec.pc), 64'd0);
        chk("rst_illegal", 64'(dec.illegal), 64'd0);
        chk("rst_halted", 64'(dec.halted), 64'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add + halt, out_ready held high.
        load(0, 32'h0022_1820);
        load(1, HALT_W);
        dec.out_ready = 1'b1;
        push_exp(32'h0022_1820, 32'd0);
        go();
        chk("t1_fetch_no_valid", 64'(dec.out_valid), 64'd0);
        @(negedge clk);
        chk("t1_valid", 64'(dec.out_valid), 64'd1);
        check_pop("t1");
        @(negedge clk);
        chk("t1_fetch2_halted", 64'(dec.halted), 64'd0);
        @(negedge clk);
        chk("t1_decode_halt_no_valid", 64'(dec.out_valid), 64'd0);
        chk("t1_decode_halt_halted", 64'(dec.halted), 64'd0);
        @(negedge clk);
        chk("t1_halted", 64'(dec.halted), 64'd1);

        // Same program, stalled for five cycles.
        dec.out_ready = 1'b0;
        go();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t2_stall_valid", 64'(dec.out_valid), 64'd1);
            chk("t2_stall_r1", 64'(dec.r1), 64'd1);
            chk("t2_stall_r3", 64'(dec.r3), 64'd3);
            chk("t2_stall_funct", 64'(dec.funct), 64'h20);
            chk("t2_stall_pc", 64'(dec.pc), 64'd0);
            @(negedge clk);
        end
        dec.out_ready = 1'b1;
        push_exp(32'h0022_1820, 32'd0);
        check_pop("t2");
        @(negedge clk);
        chk("t2_pc_after_accept", 64'(dec.pc), 64'd4);
        chk("t2_valid_dropped", 64'(dec.out_valid), 64'd0);
        run_until_halt("t2", 20, nv, ni, ipc, lpc, cyc);

        // lw (illegal), nop, or, halt.
        load(0, 32'h8C22_0000);
        load(1, 32'h0000_0000);
        load(2, 32'h00A6_2025);
        load(3, HALT_W);
        push_exp(32'h00A6_2025, 32'd8);
        go();
        run_until_halt("t3", 40, nv, ni, ipc, lpc, cyc);
        chk("t3_illegal_count", 64'(ni), 64'd1);
        chk("t3_illegal_pc", 64'(ipc), 64'd0);
        chk("t3_valid_count", 64'(nv), 64'd1);

        // Full memory of R-type words, no halt word: stops at the end.
        for (int i = 0; i < 64; i++) begin
            w = {6'd0, 5'(i), 5'(i + 1), 5'(i + 3), 5'd0, 6'(i)};
            load(i, w);
            push_exp(w, 32'(4 * i));
        end
        go();
        run_until_halt("t4", 300, nv, ni, ipc, lpc, cyc);
        chk("t4_valid_count", 64'(nv), 64'd64);
        chk("t4_last_pc", 64'(lpc), 64'd252);
        chk("t4_illegal_count", 64'(ni), 64'd0);
        chk("t4_two_cycles_per_instr", 64'(cyc), 64'd128);

        // Reset during a stall, then rerun from retained memory.
        load(0, 32'h0022_1820);
        load(1, HALT_W);
        dec.out_ready = 1'b0;
        go();
        @(negedge clk);
        chk("t5_stalled_valid", 64'(dec.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(dec.out_valid), 64'd0);
        chk("t5_rst_pc", 64'(dec.pc), 64'd0);
        chk("t5_rst_r1", 64'(dec.r1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        dec.out_ready = 1'b1;
        push_exp(32'h0022_1820, 32'd0);
        go();
        run_until_halt("t5", 20, nv, ni, ipc, lpc, cyc);
        chk("t5_valid_count", 64'(nv), 64'd1);

        // start together with load_en in IDLE: load only.
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        start     = 1'b1;
        load_en   = 1'b1;
        load_addr = 6'd0;
        load_data = 32'h00A6_2025;
        @(negedge clk);
        start   = 1'b0;
        load_en = 1'b0;
        chk("t6_no_valid_a", 64'(dec.out_valid), 64'd0);
        @(negedge clk);
        chk("t6_no_valid_b", 64'(dec.out_valid), 64'd0);
        @(negedge clk);
        chk("t6_no_valid_c", 64'(dec.out_valid), 64'd0);
        chk("t6_not_halted", 64'(dec.halted), 64'd0);
        push_exp(32'h00A6_2025, 32'd0);
        go();
        run_until_halt("t6", 20, nv, ni, ipc, lpc, cyc);
        chk("t6_valid_count", 64'(nv), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
